// File: rtl/aes_axil_regbank.sv
// AXI4-Lite register bank sitting in front of the AES datapath core.
// Holds key, input block, control/status and captured result words, issues a
// one-cycle start pulse to the core and raises a level interrupt on completion.
module aes_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int KEY_WORDS          = 4,
    parameter int BLOCK_WORDS        = 4
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic                               core_start,
    output logic                               core_mode,
    output logic [KEY_WORDS*C_S_AXI_DATA_WIDTH-1:0]   core_key,
    output logic [BLOCK_WORDS*C_S_AXI_DATA_WIDTH-1:0] core_din,
    input  logic [BLOCK_WORDS*C_S_AXI_DATA_WIDTH-1:0] core_dout,
    input  logic                               core_done,
    output logic                               irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int NB = DW / 8;

    // Word-index map: CTRL, STATUS, then KEY, DIN and DOUT blocks back to back.
    localparam int unsigned CTRL_IDX   = 0;
    localparam int unsigned STATUS_IDX = 1;
    localparam int unsigned KEY_BASE   = 2;
    localparam int unsigned DIN_BASE   = KEY_BASE + KEY_WORDS;
    localparam int unsigned DOUT_BASE  = DIN_BASE + BLOCK_WORDS;
    localparam int unsigned MAP_END    = DOUT_BASE + BLOCK_WORDS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0] key_reg  [KEY_WORDS];
    logic [DW-1:0] din_reg  [BLOCK_WORDS];
    logic [DW-1:0] dout_reg [BLOCK_WORDS];
    logic          mode_reg;
    logic          irq_en_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          start_q;
    logic          irq_q;

    logic          aw_ready_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          ar_ready_q;
    logic          rvalid_q;
    logic [1:0]    rresp_q;
    logic [DW-1:0] rdata_q;

    logic          wr_en;
    logic          rd_en;
    logic          start_req;
    logic          start_go;
    logic          wr_err;
    logic          rd_err;
    int unsigned   wr_idx;
    int unsigned   rd_idx;
    logic [DW-1:0] rd_word;

    logic          unused;
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // A write is taken on the edge where our registered READY meets both VALIDs.
    assign wr_en    = aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en    = ar_ready_q && S_AXI_ARVALID;
    assign start_go = wr_en && start_req && !busy_reg;

    // Classify the incoming write: which register, and whether it must be refused.
    always_comb begin
        wr_idx    = 32'(S_AXI_AWADDR[AW-1:2]);
        start_req = (wr_idx == CTRL_IDX) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
        if (wr_idx == CTRL_IDX)
            wr_err = busy_reg && !start_req;
        else if (wr_idx == STATUS_IDX)
            wr_err = S_AXI_WSTRB[0] && S_AXI_WDATA[0];
        else if (wr_idx < DOUT_BASE)
            wr_err = busy_reg;
        else
            wr_err = 1'b1;
    end

    // Read mux: select the addressed word, flag anything past DOUT as unmapped.
    always_comb begin
        rd_idx  = 32'(S_AXI_ARADDR[AW-1:2]);
        rd_word = '0;
        rd_err  = 1'b0;
        if (rd_idx == CTRL_IDX)
            rd_word = DW'({irq_en_reg, mode_reg, 1'b0});
        else if (rd_idx == STATUS_IDX)
            rd_word = DW'({done_reg, busy_reg});
        else if (rd_idx >= MAP_END)
            rd_err = 1'b1;
        else begin
            for (int i = 0; i < KEY_WORDS; i++)
                if (rd_idx == KEY_BASE + i) rd_word = key_reg[i];
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                if (rd_idx == DIN_BASE + i)  rd_word = din_reg[i];
                if (rd_idx == DOUT_BASE + i) rd_word = dout_reg[i];
            end
        end
    end

    // Write address/data acceptance and the write response channel.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            aw_ready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !aw_ready_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read address acceptance and the registered read data channel.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            ar_ready_q <= S_AXI_ARVALID && !rvalid_q && !ar_ready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register file, start/busy/done tracking; core completion is applied last so it beats a W1C.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < KEY_WORDS; i++) key_reg[i] <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                din_reg[i]  <= '0;
                dout_reg[i] <= '0;
            end
            mode_reg   <= 1'b0;
            irq_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            start_q <= start_go;
            if (wr_en && !wr_err) begin
                if (wr_idx == CTRL_IDX && S_AXI_WSTRB[0]) begin
                    irq_en_reg <= S_AXI_WDATA[2];
                    if (!busy_reg) mode_reg <= S_AXI_WDATA[1];
                end
                if (wr_idx == STATUS_IDX && S_AXI_WSTRB[0] && S_AXI_WDATA[1])
                    done_reg <= 1'b0;
                for (int i = 0; i < KEY_WORDS; i++)
                    if (wr_idx == KEY_BASE + i)
                        for (int b = 0; b < NB; b++)
                            if (S_AXI_WSTRB[b]) key_reg[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                for (int i = 0; i < BLOCK_WORDS; i++)
                    if (wr_idx == DIN_BASE + i)
                        for (int b = 0; b < NB; b++)
                            if (S_AXI_WSTRB[b]) din_reg[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
            if (start_go) begin
                busy_reg <= 1'b1;
                done_reg <= 1'b0;
            end
            if (core_done && busy_reg) begin
                for (int i = 0; i < BLOCK_WORDS; i++) dout_reg[i] <= core_dout[i*DW +: DW];
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    // Interrupt follows DONE gated by IRQ_EN, one cycle behind.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) irq_q <= 1'b0;
        else              irq_q <= done_reg && irq_en_reg;
    end

    genvar g;
    generate
        for (g = 0; g < KEY_WORDS; g++) begin : g_key
            assign core_key[g*DW +: DW] = key_reg[g];
        end
        for (g = 0; g < BLOCK_WORDS; g++) begin : g_din
            assign core_din[g*DW +: DW] = din_reg[g];
        end
    endgenerate

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign core_start    = start_q;
    assign core_mode     = mode_reg;
    assign irq           = irq_q;

endmodule
